// File: rtl/buffer_read_counter_mc_pkg.sv
// ---------------------------------------------------------------------------
// buffer_read_counter_mc_pkg
// Shared definitions for the multi-channel burst read tracker:
//   - ch_state_t : per-channel FSM state (idle / streaming a burst)
//   - C_LOG_2    : ceiling log2, used to size the PU id field
// ---------------------------------------------------------------------------
package buffer_read_counter_mc_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } ch_state_t;

    // Ceiling log2 for elaboration-time sizing; C_LOG_2(1) is 0, so a single
    // PU still gets a one-bit id once the +1 guard bit is added by the caller.
    function automatic int C_LOG_2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/buffer_read_counter_mc_channel.sv
// ---------------------------------------------------------------------------
// buffer_read_channel
// One read channel: an info FIFO of {pu_id, size} burst records plus the
// FSM that meters size+1 buffer pops per record against PU demand.
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   i_flush           synchronous clear of queued and active bursts
//   i_push            decoded request strobe for this channel
//   i_pushPu/Size     burst record to enqueue (size is beats-1)
//   i_readReq         PU-side demand
//   i_readEmpty       read buffer empty
//   o_pop, o_last     pop strobe and last-beat flag (combinational)
//   o_puId            PU id of the most recent beat (registered)
//   o_busy            channel is streaming a burst
//   o_infoFull        registered almost-full
//   o_infoCount       queued records, excluding the active burst
//   o_overflow        sticky: a push was dropped at true full
// ---------------------------------------------------------------------------
module buffer_read_channel
    import buffer_read_counter_mc_pkg::*;
#(
    parameter int NUM_PU      = 1,
    parameter int PU_ID_W     = 1,
    parameter int RD_SIZE_W   = 20,
    parameter int INFO_ADDR_W = 7,
    parameter int FULL_MARGIN = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_flush,
    input  logic                   i_push,
    input  logic [PU_ID_W-1:0]     i_pushPu,
    input  logic [RD_SIZE_W-1:0]   i_pushSize,
    input  logic                   i_readReq,
    input  logic                   i_readEmpty,
    output logic                   o_pop,
    output logic                   o_last,
    output logic [PU_ID_W-1:0]     o_puId,
    output logic                   o_busy,
    output logic                   o_infoFull,
    output logic [INFO_ADDR_W:0]   o_infoCount,
    output logic                   o_overflow
);

    localparam int DEPTH = 1 << INFO_ADDR_W;
    localparam int CNT_W = INFO_ADDR_W + 1;
    localparam int REC_W = PU_ID_W + RD_SIZE_W;
    localparam logic [CNT_W-1:0]   FULL_LEVEL  = CNT_W'(DEPTH - FULL_MARGIN);
    localparam logic [CNT_W-1:0]   DEPTH_LEVEL = CNT_W'(DEPTH);
    localparam logic [PU_ID_W-1:0] LAST_PU     = PU_ID_W'(NUM_PU - 1);

    logic [REC_W-1:0]       r_mem [DEPTH];
    logic [INFO_ADDR_W-1:0] r_wrPtr;
    logic [INFO_ADDR_W-1:0] r_rdPtr;
    logic [CNT_W-1:0]       r_fifoCount;
    logic                   r_infoFull;
    logic                   r_overflow;
    ch_state_t              r_state;
    logic [PU_ID_W-1:0]     r_curPu;
    logic [PU_ID_W-1:0]     r_puId;
    logic [RD_SIZE_W-1:0]   r_curMax;
    logic [RD_SIZE_W-1:0]   r_beatCount;

    logic                   w_fifoEmpty;
    logic                   w_fifoFull;
    logic                   w_beat;
    logic                   w_burstEnd;
    logic                   w_fifoPush;
    logic                   w_fifoPop;
    logic [CNT_W-1:0]       w_countNext;
    logic [PU_ID_W-1:0]     w_headPu;
    logic [RD_SIZE_W-1:0]   w_headSize;

    assign w_fifoEmpty = (r_fifoCount == '0);
    assign w_fifoFull  = (r_fifoCount == DEPTH_LEVEL);
    assign {w_headPu, w_headSize} = r_mem[r_rdPtr];

    // A beat is a granted pop: streaming, PU wants data, and data exists.
    assign w_beat     = (r_state == ST_STREAM) && i_readReq && !i_readEmpty;
    assign w_burstEnd = w_beat && (r_beatCount == r_curMax);

    // Flush wins over both FIFO ports so the queue is empty the next cycle.
    assign w_fifoPush = i_push && !w_fifoFull && !i_flush;
    assign w_fifoPop  = !w_fifoEmpty && !i_flush &&
                        ((r_state == ST_IDLE) || w_burstEnd);

    assign o_pop       = w_beat;
    assign o_last      = w_burstEnd && (r_curPu == LAST_PU);
    assign o_puId      = r_puId;
    assign o_busy      = (r_state == ST_STREAM);
    assign o_infoFull  = r_infoFull;
    assign o_infoCount = r_fifoCount;
    assign o_overflow  = r_overflow;

    // Next occupancy; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        w_countNext = r_fifoCount;
        if (w_fifoPush && !w_fifoPop) begin
            w_countNext = r_fifoCount + CNT_W'(1);
        end else if (!w_fifoPush && w_fifoPop) begin
            w_countNext = r_fifoCount - CNT_W'(1);
        end
    end

    // Record storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_fifoPush) begin
            r_mem[r_wrPtr] <= {i_pushPu, i_pushSize};
        end
    end

    // FIFO pointers, occupancy, almost-full and the sticky overflow flag.
    // almost-full is registered from the next occupancy so it lines up with
    // the count that caused it; overflow survives a flush on purpose.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wrPtr     <= '0;
            r_rdPtr     <= '0;
            r_fifoCount <= '0;
            r_infoFull  <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (i_push && w_fifoFull && !i_flush) begin
                r_overflow <= 1'b1;
            end
            if (i_flush) begin
                r_wrPtr     <= '0;
                r_rdPtr     <= '0;
                r_fifoCount <= '0;
                r_infoFull  <= 1'b0;
            end else begin
                if (w_fifoPush) begin
                    r_wrPtr <= r_wrPtr + INFO_ADDR_W'(1);
                end
                if (w_fifoPop) begin
                    r_rdPtr <= r_rdPtr + INFO_ADDR_W'(1);
                end
                r_fifoCount <= w_countNext;
                r_infoFull  <= (w_countNext >= FULL_LEVEL);
            end
        end
    end

    // Burst FSM. IDLE loads the head record; STREAM counts beats up to
    // cur_max and, on the final beat, reloads straight from the FIFO when a
    // record is waiting so consecutive bursts have no idle cycle between them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_curPu     <= '0;
            r_curMax    <= '0;
            r_beatCount <= '0;
            r_puId      <= '0;
        end else begin
            if (w_beat) begin
                r_puId <= r_curPu;
            end
            if (i_flush) begin
                r_state     <= ST_IDLE;
                r_beatCount <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (!w_fifoEmpty) begin
                            r_curPu     <= w_headPu;
                            r_curMax    <= w_headSize;
                            r_beatCount <= '0;
                            r_state     <= ST_STREAM;
                        end
                    end
                    ST_STREAM: begin
                        if (w_beat) begin
                            if (!w_burstEnd) begin
                                r_beatCount <= r_beatCount + RD_SIZE_W'(1);
                            end else if (!w_fifoEmpty) begin
                                r_curPu     <= w_headPu;
                                r_curMax    <= w_headSize;
                                r_beatCount <= '0;
                            end else begin
                                r_state <= ST_IDLE;
                            end
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/buffer_read_counter_mc.sv
// ---------------------------------------------------------------------------
// buffer_read_counter_mc
// Multi-channel burst tracker between the memory controller and the PU read
// buffers. Each rd_req is steered by d_type to one channel's info FIFO; each
// channel then meters size+1 buffer pops independently of the others.
// Ports:
//   clk, reset         clock, asynchronous active-low reset
//   flush              per-channel synchronous clear
//   rd_req, rd_req_*   request strobe, beats-1, destination PU, channel select
//   info_full          per-channel registered almost-full
//   info_count         per-channel queued bursts (flattened)
//   overflow_err       per-channel sticky drop flag
//   buffer_read_req    per-channel PU demand
//   buffer_read_empty  per-channel read buffer empty
//   buffer_read_pop    per-channel pop strobe
//   buffer_read_last   per-channel last beat of a burst to the last PU
//   pu_id              per-channel id of the last popped beat (flattened)
//   busy               per-channel streaming indicator
// ---------------------------------------------------------------------------
module buffer_read_counter_mc
    import buffer_read_counter_mc_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int NUM_PU      = 1,
    parameter int PU_ID_W     = C_LOG_2(NUM_PU) + 1,
    parameter int RD_SIZE_W   = 20,
    parameter int D_TYPE_W    = 2,
    parameter int DTYPE_BASE  = 1,
    parameter int INFO_ADDR_W = 7,
    parameter int FULL_MARGIN = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_CH-1:0]                 flush,
    input  logic                              rd_req,
    input  logic [RD_SIZE_W-1:0]              rd_req_size,
    input  logic [PU_ID_W-1:0]                rd_req_pu_id,
    input  logic [D_TYPE_W-1:0]               rd_req_d_type,
    output logic [NUM_CH-1:0]                 info_full,
    output logic [NUM_CH*(INFO_ADDR_W+1)-1:0] info_count,
    output logic [NUM_CH-1:0]                 overflow_err,
    input  logic [NUM_CH-1:0]                 buffer_read_req,
    input  logic [NUM_CH-1:0]                 buffer_read_empty,
    output logic [NUM_CH-1:0]                 buffer_read_pop,
    output logic [NUM_CH-1:0]                 buffer_read_last,
    output logic [NUM_CH*PU_ID_W-1:0]         pu_id,
    output logic [NUM_CH-1:0]                 busy
);

    localparam int CNT_W = INFO_ADDR_W + 1;

    // One channel per d_type slot starting at DTYPE_BASE; d_types outside
    // that window decode to no channel and are silently ignored.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic w_push;
        assign w_push = rd_req && (rd_req_d_type == D_TYPE_W'(DTYPE_BASE + c));

        buffer_read_channel #(
            .NUM_PU      (NUM_PU),
            .PU_ID_W     (PU_ID_W),
            .RD_SIZE_W   (RD_SIZE_W),
            .INFO_ADDR_W (INFO_ADDR_W),
            .FULL_MARGIN (FULL_MARGIN)
        ) u_channel (
            .clk         (clk),
            .reset       (reset),
            .i_flush     (flush[c]),
            .i_push      (w_push),
            .i_pushPu    (rd_req_pu_id),
            .i_pushSize  (rd_req_size),
            .i_readReq   (buffer_read_req[c]),
            .i_readEmpty (buffer_read_empty[c]),
            .o_pop       (buffer_read_pop[c]),
            .o_last      (buffer_read_last[c]),
            .o_puId      (pu_id[c*PU_ID_W +: PU_ID_W]),
            .o_busy      (busy[c]),
            .o_infoFull  (info_full[c]),
            .o_infoCount (info_count[c*CNT_W +: CNT_W]),
            .o_overflow  (overflow_err[c])
        );
    end

endmodule
